// File: rtl/alu_cc_pipe.sv
// alu_cc_pipe: registered execute-stage ALU (add/sub/and/xor) behind a
// valid/ready handshake, with a one-entry output buffer and the architectural
// condition-code register {ZF,SF,OF}.
// Optional feature macro: ALU_MUL_EN adds an iterative radix-2 signed
// multiplier (op 4) controlled by an IDLE/MUL state machine. Without the
// macro, op 4 is illegal and busy is tied low.
module alu_cc_pipe #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_of,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd4;
`endif

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow of a - b: operands differ in sign, result leaves a's sign.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // Output buffer and condition-code state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_of_q, out_of_d;
  logic             out_err_q, out_err_d;
  logic [2:0]       cc_q, cc_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             alu_err;
  logic             is_mul;

  logic             idle;
  logic             buf_free;
  logic             accept;

  assign buf_free = !out_valid_q || out_ready;
  assign in_ready = idle && buf_free;
  assign accept   = in_valid && in_ready;

  // Decode the opcode and compute the single-cycle result and overflow
  always_comb begin
    sum     = in_a + in_b;
    diff    = in_a - in_b;
    alu_res = {WIDTH{1'b0}};
    alu_of  = 1'b0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = sum;
        alu_of  = add_ovf(in_a[WIDTH-1], in_b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_of  = sub_ovf(in_a[WIDTH-1], in_b[WIDTH-1], diff[WIDTH-1]);
      end
      OP_AND: begin
        alu_res = in_a & in_b;
      end
      OP_XOR: begin
        alu_res = in_a ^ in_b;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        is_mul = 1'b1;
      end
`endif
      default: begin
        alu_err = 1'b1;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 mul_cc_q, mul_cc_d;
  logic [2*WIDTH-1:0]   pp;
  logic                 mul_iter_done;
  logic                 mul_done;
  logic [WIDTH-1:0]     mul_res;
  logic                 mul_of;
  logic [WIDTH:0]       mul_top;

  // Completion waits for a free buffer so an undelivered result is never lost.
  assign mul_iter_done = (cnt_q == CNT_W'(WIDTH));
  assign mul_done      = (state_q == S_MUL) && mul_iter_done && buf_free;
  assign mul_res       = acc_q[WIDTH-1:0];
  assign mul_top       = acc_q[2*WIDTH-1:WIDTH-1];
  // Product overflows when its upper half is not a sign-extension of bit WIDTH-1.
  assign mul_of        = !((&mul_top) || !(|mul_top));

  // State register for the multiply sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enter MUL on accepting op 4, leave when the product is written
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer outputs
  always_comb begin
    idle = 1'b1;
    busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        idle = 1'b1;
        busy = 1'b0;
      end
      S_MUL: begin
        idle = 1'b0;
        busy = 1'b1;
      end
      default: begin
        idle = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  // Multiplier datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      mul_cc_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mul_cc_q <= mul_cc_d;
    end
  end

  // Shift-add step: one multiplier bit per cycle; the top bit carries negative weight
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_cc_d = mul_cc_q;
    pp       = mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}};
    if (state_q == S_IDLE) begin
      if (accept && is_mul) begin
        cnt_d    = {CNT_W{1'b0}};
        acc_d    = {(2*WIDTH){1'b0}};
        mcand_d  = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        mplier_d = in_b;
        mul_cc_d = in_set_cc;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (!mul_iter_done) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        acc_d = acc_q - pp;
      end else begin
        acc_d = acc_q + pp;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end
`else
  // Without the multiplier the block is always ready to issue
  always_comb begin
    idle = 1'b1;
    busy = 1'b0;
  end
`endif

  // Output buffer and condition-code registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= {WIDTH{1'b0}};
      out_of_q     <= 1'b0;
      out_err_q    <= 1'b0;
      cc_q         <= CC_RESET;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_of_q     <= out_of_d;
      out_err_q    <= out_err_d;
      cc_q         <= cc_d;
    end
  end

  // Load the buffer on a single-cycle accept or multiply completion, drain on handshake
  always_comb begin
    out_valid_d  = out_valid_q && !out_ready;
    out_result_d = out_result_q;
    out_of_d     = out_of_q;
    out_err_d    = out_err_q;
    cc_d         = cc_q;
    if (accept && !is_mul) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_res;
      out_of_d     = alu_of;
      out_err_d    = alu_err;
      if (in_set_cc && !alu_err) begin
        cc_d = {(alu_res == {WIDTH{1'b0}}), alu_res[WIDTH-1], alu_of};
      end else begin
        cc_d = cc_q;
      end
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      out_valid_d  = 1'b1;
      out_result_d = mul_res;
      out_of_d     = mul_of;
      out_err_d    = 1'b0;
      if (mul_cc_q) begin
        cc_d = {(mul_res == {WIDTH{1'b0}}), mul_res[WIDTH-1], mul_of};
      end else begin
        cc_d = cc_q;
      end
`endif
    end else begin
      cc_d = cc_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_of     = out_of_q;
  assign out_err    = out_err_q;
  assign cc_zf      = cc_q[2];
  assign cc_sf      = cc_q[1];
  assign cc_of      = cc_q[0];

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Directed testbench for alu_cc_pipe (WIDTH=64). Inputs change 1 time unit
// after each rising edge; outputs are checked at the same point.
module tb_alu_cc_pipe;
  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_of;
  logic         out_err;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  alu_cc_pipe #(.WIDTH(W), .CC_RESET(3'b100)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_of(out_of), .out_err(out_err),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic sc);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_set_cc = sc;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    tick();

    // ADD overflow at the positive boundary
    drive(1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_result", out_result, 64'h8000_0000_0000_0000);
    check("add_of", {63'd0, out_of}, 64'd1);
    check("add_err", {63'd0, out_err}, 64'd0);
    check("add_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd3);
    tick();
    check("add_drained", {63'd0, out_valid}, 64'd0);

    // SUB then XOR back-to-back
    drive(1'b1, 3'd1, 64'd5, 64'd5, 1'b1);
    tick();
    check("sub_result", out_result, 64'd0);
    check("sub_valid", {63'd0, out_valid}, 64'd1);
    check("sub_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    check("sub_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 3'd3, 64'hF0, 64'h0F, 1'b0);
    tick();
    check("xor_result", out_result, 64'hFF);
    check("xor_valid", {63'd0, out_valid}, 64'd1);
    check("xor_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);

    // SUB overflow at the negative boundary, no CC update
    drive(1'b1, 3'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("subov_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
    check("subov_of", {63'd0, out_of}, 64'd1);
    check("subov_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    tick();
    check("subov_drained", {63'd0, out_valid}, 64'd0);

    // Back-pressure: AND result held while out_ready is low
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 64'hFF00, 64'h0FF0, 1'b0);
    tick();
    drive(1'b1, 3'd0, 64'd1, 64'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_result", out_result, 64'h0F00);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    check("hold_result_end", out_result, 64'h0F00);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("second_result", out_result, 64'd3);
    check("second_valid", {63'd0, out_valid}, 64'd1);
    tick();
    check("second_drained", {63'd0, out_valid}, 64'd0);

    // Set cc = {0,1,0} via XOR, then illegal opcode 6 must leave it alone
    drive(1'b1, 3'd3, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    tick();
    check("setsf_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd2);
    drive(1'b1, 3'd6, 64'd5, 64'd3, 1'b1);
    tick();
    check("ill6_err", {63'd0, out_err}, 64'd1);
    check("ill6_result", out_result, 64'd0);
    check("ill6_of", {63'd0, out_of}, 64'd0);
    check("ill6_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd2);
    drive(1'b1, 3'd2, 64'd3, 64'd1, 1'b0);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("legal_clears_err", {63'd0, out_err}, 64'd0);
    check("legal_result", out_result, 64'd1);
    tick();

`ifdef ALU_MUL_EN
    // MUL -3 * 7
    drive(1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("mul_busy_start", {63'd0, busy}, 64'd1);
    check("mul_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (W) tick();
    check("mul_busy_end", {63'd0, busy}, 64'd1);
    check("mul_not_yet", {63'd0, out_valid}, 64'd0);
    tick();
    check("mul_valid", {63'd0, out_valid}, 64'd1);
    check("mul_busy_done", {63'd0, busy}, 64'd0);
    check("mul_result", out_result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_of", {63'd0, out_of}, 64'd0);
    check("mul_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd2);
    tick();

    // MUL 2^62 * 4 overflows to zero
    drive(1'b1, 3'd4, 64'h4000_0000_0000_0000, 64'd4, 1'b0);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    repeat (W + 1) tick();
    check("mulov_valid", {63'd0, out_valid}, 64'd1);
    check("mulov_result", out_result, 64'd0);
    check("mulov_of", {63'd0, out_of}, 64'd1);
    check("mulov_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd2);
    tick();

    // Reset in the middle of a multiply
    drive(1'b1, 3'd4, 64'd9, 64'd9, 1'b1);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    repeat (10) tick();
    check("mulrst_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mulrst_busy", {63'd0, busy}, 64'd0);
    check("mulrst_valid", {63'd0, out_valid}, 64'd0);
    tick();
    rst = 1'b0;
    repeat (W + 4) tick();
    check("mulrst_no_result", {63'd0, out_valid}, 64'd0);
    check("mulrst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
`else
    // Op 4 is illegal without the multiplier
    drive(1'b1, 3'd4, 64'd3, 64'd7, 1'b1);
    tick();
    drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    check("op4_err", {63'd0, out_err}, 64'd1);
    check("op4_result", out_result, 64'd0);
    check("op4_busy", {63'd0, busy}, 64'd0);
    check("op4_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd2);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
